// File: rtl/usb_tx_packetizer.sv
`default_nettype none
// ============================================================================
// usb_tx_packetizer : full-speed USB IN/DATA0/ACK serialiser (NRZI, bit stuffing, CRC5/CRC16)
// Rev 1.0
// ============================================================================
module usb_tx_packetizer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [1:0]  tx_pkt_type,
  input  logic [6:0]  tx_addr,
  input  logic [3:0]  tx_endp,
  input  logic [63:0] tx_data,
  output logic        d_plus,
  output logic        d_minus,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    TYPE_IN    = 2'd0;
  localparam logic [1:0]    TYPE_DATA0 = 2'd1;
  localparam logic [1:0]    TYPE_RSVD  = 2'd3;
  localparam logic [7:0]    PID_IN     = 8'h69;
  localparam logic [7:0]    PID_DATA0  = 8'hC3;
  localparam logic [7:0]    PID_ACK    = 8'hD2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SYNC    = 4'd1,
    S_PID     = 4'd2,
    S_TOKEN   = 4'd3,
    S_CRC5    = 4'd4,
    S_DATA    = 4'd5,
    S_CRC16   = 4'd6,
    S_EOP_SE0 = 4'd7,
    S_EOP_J   = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    type_q, type_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [63:0]   data_q, data_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [2:0]    ones_q, ones_d;
  logic          level_q, level_d;
  logic          d_plus_q, d_plus_d;
  logic          d_minus_q, d_minus_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic          stuff_zone;
  logic          stuff;
  logic          emit;
  logic          bit_val;
  logic [7:0]    pid_byte;
  logic [10:0]   token_bits;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  always_comb begin
    case (type_q)
      TYPE_IN:    pid_byte = PID_IN;
      TYPE_DATA0: pid_byte = PID_DATA0;
      default:    pid_byte = PID_ACK;
    endcase
  end

  assign token_bits = {endp_q, addr_q};
  assign bit_end    = (cnt_q == CNT_MAX);
  assign stuff_zone = (state_q == S_SYNC)  || (state_q == S_PID)  || (state_q == S_TOKEN) ||
                      (state_q == S_CRC5)  || (state_q == S_DATA) || (state_q == S_CRC16);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    crc5_d    = crc5_q;
    crc16_d   = crc16_q;
    ones_d    = ones_q;
    level_d   = level_q;
    d_plus_d  = d_plus_q;
    d_minus_d = d_minus_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    stuff     = 1'b0;
    emit      = 1'b0;
    bit_val   = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d     = '0;
      idx_d     = '0;
      ones_d    = '0;
      level_d   = 1'b1;
      d_plus_d  = 1'b1;
      d_minus_d = 1'b0;
      if (tx_start && (tx_pkt_type != TYPE_RSVD)) begin
        state_d = S_SYNC;
        type_d  = tx_pkt_type;
        addr_d  = tx_addr;
        endp_d  = tx_endp;
        data_d  = tx_data;
        crc5_d  = 5'h1F;
        crc16_d = 16'hFFFF;
        busy_d  = 1'b1;
        emit    = 1'b1;
      end
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      if (bit_end) begin
        // A stuffed bit holds position: idx/state/CRC stay on the last real bit.
        if (stuff_zone && (ones_q == 3'd6)) begin
          stuff = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
          case (state_q)
            S_SYNC:    if (idx_q == 6'd7) begin state_d = S_PID; idx_d = '0; end
            S_PID: begin
              if (idx_q == 6'd7) begin
                idx_d = '0;
                case (type_q)
                  TYPE_IN:    state_d = S_TOKEN;
                  TYPE_DATA0: state_d = S_DATA;
                  default:    state_d = S_EOP_SE0;
                endcase
              end
            end
            S_TOKEN:   if (idx_q == 6'd10) begin state_d = S_CRC5;    idx_d = '0; end
            S_CRC5:    if (idx_q == 6'd4)  begin state_d = S_EOP_SE0; idx_d = '0; end
            S_DATA:    if (idx_q == 6'd63) begin state_d = S_CRC16;   idx_d = '0; end
            S_CRC16:   if (idx_q == 6'd15) begin state_d = S_EOP_SE0; idx_d = '0; end
            S_EOP_SE0: if (idx_q == 6'd1)  begin state_d = S_EOP_J;   idx_d = '0; end
            S_EOP_J: begin
              state_d = S_IDLE;
              idx_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
            default:   state_d = S_IDLE;
          endcase

          case (state_d)
            S_EOP_SE0: begin
              ones_d    = '0;
              d_plus_d  = 1'b0;
              d_minus_d = 1'b0;
            end
            S_EOP_J, S_IDLE: begin
              level_d   = 1'b1;
              d_plus_d  = 1'b1;
              d_minus_d = 1'b0;
            end
            default: emit = 1'b1;
          endcase
        end
      end
    end

    // Bit value of the new line position; CRC registers are already final by the CRC fields.
    case (state_d)
      S_SYNC:  bit_val = (idx_d[2:0] == 3'd7);
      S_PID:   bit_val = pid_byte[idx_d[2:0]];
      S_TOKEN: bit_val = token_bits[idx_d[3:0]];
      S_CRC5:  bit_val = ~crc5_q[3'd4 - idx_d[2:0]];
      S_DATA:  bit_val = data_q[idx_d];
      S_CRC16: bit_val = ~crc16_q[4'd15 - idx_d[3:0]];
      default: bit_val = 1'b0;
    endcase

    if (stuff) begin
      level_d = ~level_q;
      ones_d  = '0;
    end else if (emit) begin
      level_d = bit_val ? level_q : ~level_q;
      ones_d  = bit_val ? ones_q + 3'd1 : 3'd0;
      if (state_d == S_TOKEN) crc5_d  = crc5_step(crc5_q, bit_val);
      if (state_d == S_DATA)  crc16_d = crc16_step(crc16_q, bit_val);
    end

    if (stuff || emit) begin
      d_plus_d  = level_d;
      d_minus_d = ~level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      type_q    <= '0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      crc5_q    <= '0;
      crc16_q   <= '0;
      ones_q    <= '0;
      level_q   <= 1'b1;
      d_plus_q  <= 1'b1;
      d_minus_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      data_q    <= data_d;
      crc5_q    <= crc5_d;
      crc16_q   <= crc16_d;
      ones_q    <= ones_d;
      level_q   <= level_d;
      d_plus_q  <= d_plus_d;
      d_minus_q <= d_minus_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign d_plus  = d_plus_q;
  assign d_minus = d_minus_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_packetizer.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_packetizer : directed + randomized checks against a packet-level line model
// Rev 1.0
// ============================================================================
module tb_usb_tx_packetizer;

  localparam int CPB = 8;

  logic        clk;
  logic        rst;
  logic        tx_start;
  logic [1:0]  tx_pkt_type;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;
  logic [63:0] tx_data;
  logic        d_plus;
  logic        d_minus;
  logic        tx_busy;
  logic        tx_done;

  int          tests;
  int          fails;
  int          last_done_c;
  logic [1:0]  exp_q[$];
  logic [1:0]  obs[$];
  bit          dec[$];

  usb_tx_packetizer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .tx_pkt_type(tx_pkt_type),
    .tx_addr    (tx_addr),
    .tx_endp    (tx_endp),
    .tx_data    (tx_data),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [4:0] crc5_model(input logic [10:0] bits);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = bits[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_model(input logic [63:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      fb = bits[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return ~c;
  endfunction

  // Expected line symbol per bit time: field bits, then stuffing, then NRZI, then EOP.
  task automatic build_expected(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e,
                                input logic [63:0] d);
    bit          raw[$];
    logic [7:0]  pid;
    logic [10:0] tok;
    logic [4:0]  c5;
    logic [15:0] c16;
    logic        lvl;
    int          ones;
    raw.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    pid = (t == 2'd0) ? 8'h69 : (t == 2'd1) ? 8'hC3 : 8'hD2;
    for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
    if (t == 2'd0) begin
      tok = {e, a};
      for (int i = 0; i < 11; i++) raw.push_back(tok[i]);
      c5 = crc5_model(tok);
      for (int i = 4; i >= 0; i--) raw.push_back(c5[i]);
    end
    if (t == 2'd1) begin
      for (int i = 0; i < 64; i++) raw.push_back(d[i]);
      c16 = crc16_model(d);
      for (int i = 15; i >= 0; i--) raw.push_back(c16[i]);
    end
    lvl  = 1'b1;
    ones = 0;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = ~lvl;
      exp_q.push_back({lvl, ~lvl});
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_q.push_back({lvl, ~lvl});
        ones = 0;
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // NRZI-decode and destuff the captured line; counts stuffs seen inside the DATA payload.
  task automatic decode(output int data_stuffs);
    logic prev, lvl, b;
    int   ones;
    bit   stop;
    dec.delete();
    prev        = 1'b1;
    ones        = 0;
    stop        = 1'b0;
    data_stuffs = 0;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i] == 2'b00) stop = 1'b1;
      if (!stop) begin
        lvl = (obs[i] == 2'b10);
        if (ones == 6) begin
          if (dec.size() > 16 && dec.size() <= 80) data_stuffs++;
          ones = 0;
        end else begin
          b = (lvl == prev);
          dec.push_back(b);
          ones = b ? ones + 1 : 0;
        end
        prev = lvl;
      end
    end
  endtask

  function automatic logic dbit(input int i);
    return (i < dec.size()) ? dec[i] : 1'bx;
  endfunction

  task automatic issue(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e,
                       input logic [63:0] d, input bit hold);
    tx_pkt_type = t;
    tx_addr     = a;
    tx_endp     = e;
    tx_data     = d;
    tx_start    = 1'b1;
    @(posedge clk); #1;
    if (!hold) tx_start = 1'b0;
  endtask

  // Called one step after the accepting edge; returns in the tx_done cycle.
  task automatic watch(input string tag, input int release_c);
    int n, mism, first, busy_low;
    n           = exp_q.size();
    mism        = 0;
    first       = 0;
    busy_low    = 0;
    last_done_c = -1;
    obs.delete();
    for (int c = 0; c <= CPB * n; c++) begin
      if (c == release_c) tx_start = 1'b0;
      if (c % CPB == CPB / 2) obs.push_back({d_plus, d_minus});
      if (tx_done === 1'b1 && last_done_c < 0) last_done_c = c;
      if (c < CPB * n && tx_busy !== 1'b1) busy_low++;
      if (c < CPB * n) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < n; i++) begin
      if (obs[i] !== exp_q[i]) begin
        if (mism == 0) first = i;
        mism++;
      end
    end
    check({tag, "_line_seq_mismatches"}, mism, 0);
    if (mism > 0)
      $display("  %s first differing bit time %0d: observed=%b expected=%b",
               tag, first, obs[first], exp_q[first]);
    check({tag, "_busy_drops"}, busy_low, 0);
    check({tag, "_done_cycle"}, last_done_c, CPB * n);
    check({tag, "_busy_after_done"}, tx_busy, 1'b0);
  endtask

  task automatic check_fields(input string tag, input logic [1:0] t, input logic [6:0] a,
                              input logic [3:0] e, input logic [63:0] d, output int stuffs);
    logic [15:0] v;
    decode(stuffs);
    v = '0;
    if (t == 2'd0) begin
      for (int k = 0; k < 5; k++) v = {v[14:0], dbit(27 + k)};
      check({tag, "_crc5"}, v, crc5_model({e, a}));
    end
    if (t == 2'd1) begin
      for (int k = 0; k < 16; k++) v = {v[14:0], dbit(80 + k)};
      check({tag, "_crc16"}, v, crc16_model(d));
    end
  endtask

  initial begin
    logic [1:0]  rt;
    logic [6:0]  ra;
    logic [3:0]  re;
    logic [63:0] rd;
    int          stuffs;
    int          idle_bad;

    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    tx_start    = 1'b0;
    tx_pkt_type = 2'd0;
    tx_addr     = '0;
    tx_endp     = '0;
    tx_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_lines", {d_plus, d_minus}, 2'b10);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // T1: ACK timing and line sequence
    build_expected(2'd2, 7'h0, 4'h0, 64'h0);
    issue(2'd2, 7'h0, 4'h0, 64'h0, 1'b0);
    check("t1_first_sync_k", {d_plus, d_minus}, 2'b01);
    watch("t1_ack", -1);
    check("t1_done_152", last_done_c, 152);
    check("t1_idle_j", {d_plus, d_minus}, 2'b10);

    // T2: IN token CRC5
    build_expected(2'd0, 7'h15, 4'hE, 64'h0);
    issue(2'd0, 7'h15, 4'hE, 64'h0, 1'b0);
    watch("t2_in", -1);
    check_fields("t2_in", 2'd0, 7'h15, 4'hE, 64'h0, stuffs);
    check("t2_crc5_value", {dbit(27), dbit(28), dbit(29), dbit(30), dbit(31)}, 5'h17);

    // T3: all-ones DATA0 exercises stuffing inside the payload
    build_expected(2'd1, 7'h0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(2'd1, 7'h0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    watch("t3_data_ones", -1);
    check_fields("t3_data_ones", 2'd1, 7'h0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, stuffs);
    check("t3_payload_stuffs", stuffs, 11);

    // T4: async reset in the middle of the DATA field
    rd = {$urandom, $urandom};
    issue(2'd1, 7'h0, 4'h0, rd, 1'b0);
    repeat (CPB * 30) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t4_rst_lines", {d_plus, d_minus}, 2'b10);
    check("t4_rst_busy", tx_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (CPB * 2) begin @(posedge clk); #1; end
    check("t4_post_rst_lines", {d_plus, d_minus}, 2'b10);
    check("t4_post_rst_done", tx_done, 1'b0);
    rd = {$urandom, $urandom};
    build_expected(2'd1, 7'h0, 4'h0, rd);
    issue(2'd1, 7'h0, 4'h0, rd, 1'b0);
    watch("t4_clean", -1);
    check_fields("t4_clean", 2'd1, 7'h0, 4'h0, rd, stuffs);

    // T5: start while busy ignored; reserved type ignored in IDLE
    build_expected(2'd2, 7'h0, 4'h0, 64'h0);
    issue(2'd2, 7'h0, 4'h0, 64'h0, 1'b0);
    tx_pkt_type = 2'd1;
    tx_start    = 1'b1;
    watch("t5_busy_start", CPB * exp_q.size() - 2);
    idle_bad    = 0;
    tx_pkt_type = 2'd3;
    tx_start    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 4) tx_start = 1'b0;
      @(posedge clk); #1;
      if (tx_busy !== 1'b0 || tx_done !== 1'b0 || {d_plus, d_minus} !== 2'b10) idle_bad++;
    end
    check("t5_reserved_idle_violations", idle_bad, 0);

    // T6: tx_start held across tx_done gives back-to-back packets
    ra = 7'($urandom);
    re = 4'($urandom);
    build_expected(2'd0, ra, re, 64'h0);
    issue(2'd0, ra, re, 64'h0, 1'b1);
    rd          = {$urandom, $urandom};
    tx_pkt_type = 2'd1;
    tx_data     = rd;
    watch("t6_first", -1);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("t6_second_sync_k", {d_plus, d_minus}, 2'b01);
    check("t6_second_busy", tx_busy, 1'b1);
    build_expected(2'd1, ra, re, rd);
    watch("t6_second", -1);
    check_fields("t6_second", 2'd1, ra, re, rd, stuffs);

    // Randomized packets
    for (int r = 0; r < 8; r++) begin
      rt = 2'($urandom_range(0, 2));
      ra = 7'($urandom);
      re = 4'($urandom);
      rd = {$urandom, $urandom};
      if (r == 3) rd = 64'hFFFF_0000_FFFF_FFFF;
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      build_expected(rt, ra, re, rd);
      issue(rt, ra, re, rd, 1'b0);
      watch($sformatf("rand%0d", r), -1);
      check_fields($sformatf("rand%0d", r), rt, ra, re, rd, stuffs);
    end

    repeat (4) begin @(posedge clk); #1; end
    check("final_idle_lines", {d_plus, d_minus}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
